// File: rtl/six_step_sequencer_if.sv
`default_nettype none
// ============================================================================
// six_step_sequencer_if : control/phase-command bundle for six_step_sequencer
// Rev 1.0
// ============================================================================
interface six_step_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             en_i;
  logic             dir_i;
  logic [CNT_W-1:0] step_period_i;
  logic             fault_i;
  logic [2:0]       phA_o;
  logic [2:0]       phB_o;
  logic [2:0]       phC_o;
  logic [2:0]       step_idx_o;
  logic             step_tick_o;
  logic             busy_o;
  logic             fault_latched_o;

  modport master (
    output en_i, dir_i, step_period_i, fault_i,
    input  phA_o, phB_o, phC_o, step_idx_o, step_tick_o, busy_o, fault_latched_o
  );

  modport slave (
    input  en_i, dir_i, step_period_i, fault_i,
    output phA_o, phB_o, phC_o, step_idx_o, step_tick_o, busy_o, fault_latched_o
  );
endinterface
`default_nettype wire

// File: rtl/six_step_sequencer.sv
`default_nettype none
// ============================================================================
// six_step_sequencer : six-step commutation with dead time and fault shutdown
// Rev 1.0
// ============================================================================
module six_step_sequencer #(
  parameter int CNT_W       = 16,
  parameter int DEAD_CYCLES = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  six_step_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DRIVE = 2'd2,
    S_DEAD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_dead_last = CNT_W'(DEAD_CYCLES - 1);

  // Packed {A,B,C}: 0 = off, 1 = high side, 2 = low side.
  function automatic logic [8:0] step_codes(input logic [2:0] s);
    case (s)
      3'd0:    return {3'd1, 3'd2, 3'd0};
      3'd1:    return {3'd1, 3'd0, 3'd2};
      3'd2:    return {3'd0, 3'd1, 3'd2};
      3'd3:    return {3'd2, 3'd1, 3'd0};
      3'd4:    return {3'd2, 3'd0, 3'd1};
      3'd5:    return {3'd0, 3'd2, 3'd1};
      default: return 9'd0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [2:0]       step_q, step_d;
  logic [2:0]       next_q, next_d;
  logic             flt_q, flt_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic [8:0]       ph_q, ph_d;
  logic [CNT_W-1:0] drive_last;
  logic [8:0]       cur_codes, nxt_codes;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    shadow_d   = shadow_q;
    step_d     = step_q;
    next_d     = next_q;
    flt_d      = flt_q;
    tick_d     = 1'b0;
    drive_last = (shadow_q == '0) ? '0 : shadow_q - CNT_W'(1);

    if (!bus.en_i && !bus.fault_i) begin
      flt_d = 1'b0;
    end

    // Fault outranks enable; both outrank normal sequencing.
    if (bus.fault_i) begin
      state_d = S_IDLE;
      flt_d   = 1'b1;
    end else if (state_q != S_IDLE && !bus.en_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.en_i && !flt_q) begin
            state_d  = S_START;
            shadow_d = bus.step_period_i;
          end
        end
        S_START: begin
          if (cnt_q == c_dead_last) state_d = S_DRIVE;
        end
        S_DRIVE: begin
          if (cnt_q == drive_last) begin
            if (bus.dir_i) next_d = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
            else           next_d = (step_q == 3'd0) ? 3'd5 : step_q - 3'd1;
            shadow_d = bus.step_period_i;
            state_d  = S_DEAD;
          end
        end
        S_DEAD: begin
          if (cnt_q == c_dead_last) begin
            step_d  = next_q;
            tick_d  = 1'b1;
            state_d = S_DRIVE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d != state_q || state_d == S_IDLE) begin
      cnt_d = '0;
    end

    // Outputs are registered from the next-state values so they line up with the state.
    cur_codes = step_codes(step_d);
    nxt_codes = step_codes(next_d);
    busy_d    = (state_d != S_IDLE);
    ph_d      = 9'd0;
    if (state_d == S_DRIVE) begin
      ph_d = cur_codes;
    end else if (state_d == S_DEAD) begin
      for (int p = 0; p < 3; p++) begin
        if (cur_codes[3*p +: 3] == nxt_codes[3*p +: 3]) begin
          ph_d[3*p +: 3] = cur_codes[3*p +: 3];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      step_q   <= 3'd0;
      next_q   <= 3'd0;
      flt_q    <= 1'b0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
      ph_q     <= 9'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      step_q   <= step_d;
      next_q   <= next_d;
      flt_q    <= flt_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
      ph_q     <= ph_d;
    end
  end

  assign bus.phA_o           = ph_q[8:6];
  assign bus.phB_o           = ph_q[5:3];
  assign bus.phC_o           = ph_q[2:0];
  assign bus.step_idx_o      = step_q;
  assign bus.step_tick_o     = tick_q;
  assign bus.busy_o          = busy_q;
  assign bus.fault_latched_o = flt_q;

endmodule
`default_nettype wire

// File: tb/tb_six_step_sequencer.sv
`default_nettype none
// ============================================================================
// tb_six_step_sequencer : directed and random checks against a behavioural model
// Rev 1.0
// ============================================================================
module tb_six_step_sequencer;

  localparam int CNT_W       = 16;
  localparam int DEAD_CYCLES = 4;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   tick_seen;

  six_step_sequencer_if #(.CNT_W(CNT_W)) bus ();

  six_step_sequencer #(
    .CNT_W       (CNT_W),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: mode 0 idle, 1 start, 2 drive, 3 dead; m_left counts cycles remaining.
  int tbl [0:5][0:2] = '{'{1,2,0}, '{1,0,2}, '{0,1,2}, '{2,1,0}, '{2,0,1}, '{0,2,1}};
  int m_mode, m_left, m_step, m_next, m_period;
  bit m_flt, m_tick;

  function automatic int drive_len(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  task automatic model_edge();
    int en_v, dir_v, flt_v, per_v;
    en_v  = int'(bus.en_i);
    dir_v = int'(bus.dir_i);
    flt_v = int'(bus.fault_i);
    per_v = int'(bus.step_period_i);
    m_tick = 1'b0;
    if (!rst) begin
      m_mode = 0; m_left = 0; m_step = 0; m_next = 0; m_period = 0; m_flt = 1'b0;
    end else begin
      if (en_v == 0 && flt_v == 0) m_flt = 1'b0;
      if (flt_v != 0) begin
        m_mode = 0;
        m_flt  = 1'b1;
      end else if (m_mode != 0 && en_v == 0) begin
        m_mode = 0;
      end else begin
        case (m_mode)
          0: if (en_v != 0 && !m_flt) begin
               m_mode = 1; m_left = DEAD_CYCLES; m_period = per_v;
             end
          1: begin
               m_left--;
               if (m_left == 0) begin m_mode = 2; m_left = drive_len(m_period); end
             end
          2: begin
               m_left--;
               if (m_left == 0) begin
                 m_next   = (m_step + (dir_v != 0 ? 1 : 5)) % 6;
                 m_period = per_v;
                 m_mode   = 3;
                 m_left   = DEAD_CYCLES;
               end
             end
          default: begin
               m_left--;
               if (m_left == 0) begin
                 m_step = m_next; m_tick = 1'b1;
                 m_mode = 2; m_left = drive_len(m_period);
               end
             end
        endcase
      end
    end
  endtask

  function automatic logic [14:0] exp_vec();
    logic [2:0] ph [0:2];
    for (int p = 0; p < 3; p++) begin
      ph[p] = 3'd0;
      if (m_mode == 2) ph[p] = 3'(tbl[m_step][p]);
      else if (m_mode == 3 && tbl[m_step][p] == tbl[m_next][p]) ph[p] = 3'(tbl[m_step][p]);
    end
    return {ph[0], ph[1], ph[2], 3'(m_step), m_tick, (m_mode != 0), m_flt};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {bus.phA_o, bus.phB_o, bus.phC_o, bus.step_idx_o,
            bus.step_tick_o, bus.busy_o, bus.fault_latched_o};
  endfunction

  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    if (bus.step_tick_o === 1'b1) tick_seen++;
    check(tag, dut_vec(), exp_vec());
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  initial begin
    vectors = 0; miscompares = 0; tick_seen = 0;
    m_mode = 0; m_left = 0; m_step = 0; m_next = 0; m_period = 0; m_flt = 1'b0; m_tick = 1'b0;

    // 1: reset held with en high
    rst = 1'b0;
    bus.en_i = 1'b1; bus.dir_i = 1'b1; bus.step_period_i = 16'd10; bus.fault_i = 1'b0;
    run("t1_reset", 2);
    check("t1_reset_zero", dut_vec(), 15'd0);

    // 2: forward, period 10
    rst = 1'b1;
    run("t2_fwd", 4 + 10 + 4 + 11);

    // 3: reverse from step 0
    rst = 1'b0; bus.en_i = 1'b0;
    run("t3_rst", 1);
    rst = 1'b1; bus.dir_i = 1'b0; bus.en_i = 1'b1;
    run("t3_rev", 4 + 10 + 4 + 3);
    check("t3_step5", {12'd0, bus.step_idx_o}, 15'd5);

    // 4: free-run forward, period 3, seven commutations
    rst = 1'b0; bus.en_i = 1'b0;
    run("t4_rst", 1);
    rst = 1'b1; bus.dir_i = 1'b1; bus.step_period_i = 16'd3; bus.en_i = 1'b1;
    tick_seen = 0;
    run("t4_run", 4 + 7 * (3 + 4) + 2);
    check("t4_tick_count", 15'(tick_seen), 15'd7);

    // 5: fault mid-DRIVE, blocked restart, clear, resume
    bus.step_period_i = 16'd6;
    run("t5_pre", 3);
    bus.fault_i = 1'b1;
    run("t5_fault", 1);
    bus.fault_i = 1'b0;
    run("t5_blocked", 4);
    bus.en_i = 1'b0;
    run("t5_clear", 1);
    bus.en_i = 1'b1;
    run("t5_resume", 4 + 6 + 4 + 2);

    // 6: zero period, then en falls on a DRIVE cycle
    bus.en_i = 1'b0;
    run("t6_idle", 1);
    bus.step_period_i = 16'd0; bus.en_i = 1'b1;
    run("t6_run", 4 + 1 + 4 + 1);
    for (int k = 0; k < 20 && m_mode != 2; k++) cyc("t6_seek");
    bus.en_i = 1'b0;
    run("t6_drop", 1);
    check("t6_hold_idx", {12'd0, bus.step_idx_o}, 15'(m_step));

    // 7: random traffic
    for (int i = 0; i < 400; i++) begin
      rst               = ($urandom_range(0, 149) != 0);
      bus.en_i          = ($urandom_range(0, 19) != 0);
      bus.dir_i         = $urandom_range(0, 1) != 0;
      bus.fault_i       = ($urandom_range(0, 59) == 0);
      bus.step_period_i = 16'($urandom_range(0, 5));
      cyc("t7_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/six_step_sequencer.md
Name: six_step_sequencer

Overview:
- Generates the phase command codes (PhA/PhB/PhC) that drive the three-phase modulator. Sequences six-step commutation with programmable step duration, direction and dead-time insertion.
- Sits between the control registers and the modulator.
- Provides a fault shutdown path that forces all phases off.

Parameters:
- CNT_W, 16, width of step_period and of the internal step counter.
- DEAD_CYCLES, 4, dead-time length in clk cycles; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising clk edge.
- en  in  1  run enable; level-sensitive.
- dir  in  1  1 = forward (step+1), 0 = reverse (step-1).
- step_period  in  CNT_W  DRIVE duration per step in clk cycles; 0 is treated as 1.
- fault  in  1  asynchronous-source fault, already synchronised upstream.
- phA  out  3  phase A code to modulator PhA.
- phB  out  3  phase B code to modulator PhB.
- phC  out  3  phase C code to modulator PhC.
- step_idx  out  3  current commutation step, 0..5.
- step_tick  out  1  one-cycle pulse when step_idx advances.
- busy  out  1  high in any state other than IDLE.
- fault_latched  out  1  sticky fault flag.

Behaviour:
- Phase codes: 3'd0 = off (both switches open), 3'd1 = high-side on, 3'd2 = low-side on. Other codes are never produced.
- Step table (A,B,C):
  - 0: 1,2,0
  - 1: 1,0,2
  - 2: 0,1,2
  - 3: 2,1,0
  - 4: 2,0,1
  - 5: 0,2,1
- All outputs are registered.
- Reset (rst=0 at edge): state IDLE, all outputs 0, step_idx=0, counters 0, fault_latched=0. Reset overrides everything, including mid-step and mid-dead-time.
- FSM states: IDLE, START, DRIVE, DEAD.
- IDLE:
  - Phases 0, busy=0.
  - en=1 and fault_latched=0 -> START.
  - step_period is sampled into a shadow register on this transition.
- START:
  - Phases 0 for exactly DEAD_CYCLES cycles.
  - Then -> DRIVE at the current step_idx; step_idx is not advanced and step_tick is not pulsed.
- DRIVE:
  - Phases = table[step_idx].
  - Lasts exactly max(shadow_period,1) cycles.
  - On the last cycle: sample dir, compute next = step_idx±1 mod 6 (5+1 -> 0, 0-1 -> 5), resample step_period into the shadow register, then -> DEAD.
- DEAD:
  - Lasts DEAD_CYCLES cycles.
  - Per phase: output = table[step_idx] code if it equals table[next], else 0. The phase leaving its state is off; unchanged phases keep conducting.
  - On exit: step_idx <= next, step_tick=1 for that one cycle, -> DRIVE.
  - Phases show table[next] in the same cycle step_idx updates.
- en=0 in any non-IDLE state: -> IDLE on the next edge, phases 0. step_idx is retained, so a restart resumes at the same step.
- fault=1 in any state:
  - Next edge: -> IDLE, phases 0, fault_latched=1.
  - Priority: fault over en.
  - Restart is blocked while fault_latched=1.
  - fault_latched clears only when en=0 and fault=0 are sampled together, or on reset.
- Simultaneous events:
  - DRIVE end and en falling on the same edge: en wins, go to IDLE with no DEAD and no step_tick.
  - step_period changes mid-step: ignored until the next sample point.
- The counter never wraps inside a step; it compares against shadow_period-1 and reloads to 0 on every state entry.

Test Plan:
1. Reset with rst=0 for 2 cycles while en=1 -> all outputs 0, busy=0, step_idx=0.
2. DEAD_CYCLES=4, step_period=10, dir=1, en rises -> phases 0 for 4 cycles; then A=1 B=2 C=0 for 10 cycles; then dead phase A=1 B=0 C=0 for 4 cycles; then A=1 B=0 C=2 with step_idx=1 and a one-cycle step_tick.
3. dir=0 from step 0 -> next step_idx=5. Dead phase A=0 B=2 C=0 (B unchanged), then A=0 B=2 C=1.
4. Free-run forward for 7 steps, step_period=3 -> step_idx sequence 0,1,2,3,4,5,0,1. DRIVE is exactly 3 cycles each, step_tick count is 7. No cycle has the same phase at 1 and 2 within one DEAD window.
5. Assert fault mid-DRIVE -> phases 0 next cycle, fault_latched=1, busy=0. Re-raising en with fault_latched still set gives no restart. en=0 clears the flag; en=1 then restarts via START at the retained step_idx.
6. step_period=0 -> each DRIVE lasts 1 cycle. en falls on the DRIVE last cycle -> IDLE, step_idx unchanged, no step_tick.
